// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
//   Bundles the start/busy/done handshake, operands and result of the
//   bit-serial subtractor.
//   master : requester side (drives start/a/b/bin, observes the rest)
//   slave  : subtractor side (drives busy/done/diff/borrow/dbg_state)
//   dbg_state mirrors the subtractor FSM encoding (0=IDLE, 1=SHIFT, 2=DONE).
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic [1:0]       dbg_state;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, borrow, dbg_state
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, borrow, dbg_state
  );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor: computes a - b - bin one bit per clock,
//   LSB first, through a single full-subtractor cell and a registered borrow.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous, active-high reset
//     bus  - serial_subtractor_if.slave: start/a/b/bin in,
//            busy/done/diff/borrow/dbg_state out
//
//   Handshake: start is a request that is only looked at in IDLE; when it is
//   sampled high there the operands are captured on that same edge and busy
//   rises. busy stays high for exactly WIDTH cycles, then done pulses for one
//   cycle with diff/borrow already updated. start during SHIFT or DONE is
//   dropped, so the requester must wait for done to fall before asking again.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sd_q, sd_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Full-subtractor cell on the current LSBs and the running borrow.
  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

  assign d_bit    = sa_q[0] ^ sb_q[0] ^ br_q;
  assign br_next  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
  // Result bits enter at the MSB and move down, so after WIDTH shifts bit 0
  // of the result sits at bit 0.
  assign res_next = {d_bit, sd_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sd_d     = sd_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          br_d    = bus.bin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sd_d  = res_next;
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        br_d  = br_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Only here do the visible result registers change, so partial
          // results never leak onto diff/borrow.
          diff_d   = res_next;
          borrow_d = br_next;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sd_q     <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sd_q     <= sd_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.dbg_state = state_q;

endmodule
